// File: rtl/display_timing_pkg.sv
// Shared constants and phase encoding for the raster timing generator.
// Defaults describe 640x480 at the pixel clock (800x525 total).
package display_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter with step enable, wrap flag and the
// ACTIVE->FRONT->SYNC->BACK phase FSM. Used for both H and V.
module timing_axis_counter
  import display_timing_pkg::*;
#(
  parameter int unsigned ACTIVE       = DEF_H_ACTIVE,
  parameter int unsigned FRONT        = DEF_H_FP,
  parameter int unsigned SYNC         = DEF_H_SYNC,
  parameter int unsigned BACK         = DEF_H_BP,
  parameter bit          START_AT_END = 1'b0,
  localparam int unsigned Total       = ACTIVE + FRONT + SYNC + BACK,
  localparam int unsigned CntW        = $clog2(Total)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  output logic [CntW-1:0] count,
  output phase_e          phase,
  output phase_e          phase_next,
  output logic            wrap
);

  localparam logic [CntW-1:0] ActEnd   = CntW'(ACTIVE - 1);
  localparam logic [CntW-1:0] FrontEnd = CntW'(ACTIVE + FRONT - 1);
  localparam logic [CntW-1:0] SyncEnd  = CntW'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(Total - 1);
  localparam logic [CntW-1:0] StartCnt = START_AT_END ? LastCnt : '0;
  localparam phase_e          StartPh  = START_AT_END ? PH_BACK : PH_ACTIVE;

  logic [CntW-1:0] count_q, count_d;
  phase_e          phase_q, phase_d;

  assign wrap = step && (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = (count_q == LastCnt) ? '0 : count_q + 1'b1;
      case (phase_q)
        PH_ACTIVE: if (count_q == ActEnd)   phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == FrontEnd) phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == SyncEnd)  phase_d = PH_BACK;
        PH_BACK:   if (count_q == LastCnt)  phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= StartCnt;
      phase_q <= StartPh;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign phase_next = phase_d;

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator driving HSync/VSync/ActiveVideo and the Addr0 counter controls.
// Define ADDR_PREFETCH_EN to run Addr0 one pixel ahead for a one-cycle memory read latency.
module display_timing_gen
  import display_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       Reset,
  output logic       HSync,
  output logic       VSync,
  output logic       ActiveVideo,
  output logic [9:0] PixelX,
  output logic [9:0] PixelY,
  output logic       FrameStart,
  output logic       ResetAddr0,
  output logic       IncAddr0
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

`ifdef ADDR_PREFETCH_EN
  localparam bit StartAtEnd = 1'b1;
`else
  localparam bit StartAtEnd = 1'b0;
`endif

  localparam int unsigned  StartX = StartAtEnd ? HTotal - 1 : 0;
  localparam int unsigned  StartY = StartAtEnd ? VTotal - 1 : 0;
  localparam logic [HW-1:0] HPre  = HW'(HTotal - 2);
  localparam logic [VW-1:0] VLast = VW'(VTotal - 1);

  // Axis counters hold the position shown on the next cycle; outputs register its decode.
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  phase_e        h_ph, v_ph, h_ph_nxt, v_ph_nxt;
  logic          h_wrap, v_wrap;

  timing_axis_counter #(
    .ACTIVE      (H_ACTIVE),
    .FRONT       (H_FP),
    .SYNC        (H_SYNC),
    .BACK        (H_BP),
    .START_AT_END(StartAtEnd)
  ) u_h_axis (
    .clk       (clk),
    .reset     (Reset),
    .step      (1'b1),
    .count     (h_cnt),
    .phase     (h_ph),
    .phase_next(h_ph_nxt),
    .wrap      (h_wrap)
  );

  timing_axis_counter #(
    .ACTIVE      (V_ACTIVE),
    .FRONT       (V_FP),
    .SYNC        (V_SYNC),
    .BACK        (V_BP),
    .START_AT_END(StartAtEnd)
  ) u_v_axis (
    .clk       (clk),
    .reset     (Reset),
    .step      (h_wrap),
    .count     (v_cnt),
    .phase     (v_ph),
    .phase_next(v_ph_nxt),
    .wrap      (v_wrap)
  );

  logic       hsync_d, vsync_d, active_d, fstart_d, clr_d, inc_d;
  logic       hsync_q, vsync_q, active_q, fstart_q, clr_q, inc_q;
  logic [9:0] px_q, py_q;

  always_comb begin
    hsync_d  = (h_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (v_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    active_d = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
    fstart_d = (h_cnt == '0) && (v_cnt == '0);
`ifdef ADDR_PREFETCH_EN
    clr_d    = (h_cnt == HPre) && (v_cnt == VLast);
    inc_d    = (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
`else
    clr_d    = v_wrap;
    inc_d    = active_d;
`endif
  end

`ifdef ADDR_PREFETCH_EN
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`else
  logic [3:0] unused_ph_nxt;
  logic [HW-1:0] unused_hpre;
  assign unused_ph_nxt = {h_ph_nxt, v_ph_nxt};
  assign unused_hpre   = HPre;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b0;
      fstart_q <= 1'b0;
      clr_q    <= 1'b1;
      inc_q    <= 1'b0;
      px_q     <= 10'(StartX);
      py_q     <= 10'(StartY);
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fstart_q <= fstart_d;
      clr_q    <= clr_d;
      inc_q    <= inc_d;
      px_q     <= 10'(h_cnt);
      py_q     <= 10'(v_cnt);
    end
  end

  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign ActiveVideo = active_q;
  assign FrameStart  = fstart_q;
  assign ResetAddr0  = clr_q;
  assign IncAddr0    = inc_q;
  assign PixelX      = px_q;
  assign PixelY      = py_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: two shrunken-timing DUTs (SYNC_POL 0/1) and one default DUT,
// checked every cycle against a raster-index model; honours ADDR_PREFETCH_EN.
module tb_display_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp; int va; int vfp; int vs; int vbp;
  } tim_t;

  localparam tim_t TS = '{ha:40, hfp:4, hs:6, hbp:5, va:20, vfp:2, vs:2, vbp:3};
  localparam tim_t TD = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33};
  localparam int HTS = 55;
  localparam int VTS = 27;
  localparam int NS  = HTS * VTS;
  localparam int HTD = 800;
  localparam int ND  = 800 * 525;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_hs, s_vs, s_av, s_fs, s_ra, s_ia;
  logic       p_hs, p_vs, p_av, p_fs, p_ra, p_ia;
  logic       d_hs, d_vs, d_av, d_fs, d_ra, d_ia;
  logic [9:0] s_px, s_py, p_px, p_py, d_px, d_py;

  display_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_dut_s (
    .clk(clk), .Reset(Reset), .HSync(s_hs), .VSync(s_vs), .ActiveVideo(s_av),
    .PixelX(s_px), .PixelY(s_py), .FrameStart(s_fs), .ResetAddr0(s_ra), .IncAddr0(s_ia)
  );

  display_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_dut_p (
    .clk(clk), .Reset(Reset), .HSync(p_hs), .VSync(p_vs), .ActiveVideo(p_av),
    .PixelX(p_px), .PixelY(p_py), .FrameStart(p_fs), .ResetAddr0(p_ra), .IncAddr0(p_ia)
  );

  display_timing_gen u_dut_d (
    .clk(clk), .Reset(Reset), .HSync(d_hs), .VSync(d_vs), .ActiveVideo(d_av),
    .PixelX(d_px), .PixelY(d_py), .FrameStart(d_fs), .ResetAddr0(d_ra), .IncAddr0(d_ia)
  );

  logic [77:0] obs_all;
  assign obs_all = {s_hs, s_vs, s_av, s_fs, s_ra, s_ia, s_px, s_py,
                    p_hs, p_vs, p_av, p_fs, p_ra, p_ia, p_px, p_py,
                    d_hs, d_vs, d_av, d_fs, d_ra, d_ia, d_px, d_py};

  int checks = 0;
  int failures = 0;
  int addr = -7;
  int s_next = 0, s_shown = 0, d_next = 0, d_shown = 0;
  bit s_rst = 1'b1, d_rst = 1'b1;

  function automatic int start_pos(input int n);
`ifdef ADDR_PREFETCH_EN
    return n - 1;
`else
    return 0;
`endif
  endfunction

  // Raster model: linear index p -> expected {HSync,VSync,Active,FrameStart,ResetAddr0,IncAddr0,X,Y}
  function automatic logic [25:0] exp_vec(input tim_t t, input int p, input bit rst,
                                          input bit pol);
    int ht, vt, n, q, x, y;
    bit act, hsa, vsa, ra, ia;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    n = ht * vt;
    q = rst ? start_pos(n) : p;
    x = q % ht;
    y = q / ht;
    act = (x < t.ha) && (y < t.va);
    hsa = (x >= t.ha + t.hfp) && (x < t.ha + t.hfp + t.hs);
    vsa = (y >= t.va + t.vfp) && (y < t.va + t.vfp + t.vs);
`ifdef ADDR_PREFETCH_EN
    ia = ((((q + 1) % n) % ht) < t.ha) && ((((q + 1) % n) / ht) < t.va);
    ra = (q == n - 2);
`else
    ia = act;
    ra = (q == n - 1);
`endif
    if (rst) return {~pol, ~pol, 1'b0, 1'b0, 1'b1, 1'b0, 10'(x), 10'(y)};
    return {hsa ? pol : ~pol, vsa ? pol : ~pol, act, q == 0, ra, ia, 10'(x), 10'(y)};
  endfunction

  function automatic logic [77:0] exp_all();
    return {exp_vec(TS, s_shown, s_rst, 1'b0), exp_vec(TS, s_shown, s_rst, 1'b1),
            exp_vec(TD, d_shown, d_rst, 1'b0)};
  endfunction

  // Expected Addr0 while an active pixel of the small DUT is shown, else -1.
  function automatic int exp_addr();
    int x, y;
    if (s_rst) return -1;
    x = s_shown % HTS;
    y = s_shown / HTS;
    if (x >= TS.ha || y >= TS.va) return -1;
`ifdef ADDR_PREFETCH_EN
    return y * TS.ha + x + 1;
`else
    return y * TS.ha + x;
`endif
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      s_rst  <= 1'b1;
      s_next <= start_pos(NS);
      d_rst  <= 1'b1;
      d_next <= start_pos(ND);
    end else begin
      s_rst   <= 1'b0;
      s_shown <= s_next;
      s_next  <= (s_next + 1) % NS;
      d_rst   <= 1'b0;
      d_shown <= d_next;
      d_next  <= (d_next + 1) % ND;
    end
  end

  // Downstream Addr0 counter, stepped from the controls seen this cycle.
  task automatic adv_addr();
    if (s_ra === 1'b1) addr = 0;
    else if (s_ia === 1'b1) addr = addr + 1;
  endtask

  task automatic test_reset();
    int ea;
    bit seen_first;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_all !== exp_all()) begin
        failures++;
        $display("FAIL reset_hold t=%0t got=%h want=%h", $time, obs_all, exp_all());
      end
      adv_addr();
    end
    Reset = 1'b0;
    seen_first = 1'b0;
    for (int i = 0; i < 2 * HTS + 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_all !== exp_all()) begin
        failures++;
        $display("FAIL reset_release t=%0t got=%h want=%h", $time, obs_all, exp_all());
      end
      if (!s_rst && s_shown == 0 && !seen_first) begin
        seen_first = 1'b1;
        checks++;
        if ({s_av, s_fs} !== 2'b11) begin
          failures++;
          $display("FAIL first_pixel av_fs got=%b want=11", {s_av, s_fs});
        end
      end
      ea = exp_addr();
      if (ea >= 0) begin
        checks++;
        if (addr != ea) begin
          failures++;
          $display("FAIL reset_addr0 t=%0t got=%0d want=%0d", $time, addr, ea);
        end
      end
      adv_addr();
    end
    checks++;
    if (!seen_first) begin
      failures++;
      $display("FAIL first_pixel_seen got=0 want=1");
    end
  endtask

  task automatic test_line();
    int ea, n_av, n_hs;
    n_av = 0;
    n_hs = 0;
    for (int i = 0; i < HTD; i++) begin
      @(negedge clk);
      checks++;
      if (obs_all !== exp_all()) begin
        failures++;
        $display("FAIL line_vec t=%0t got=%h want=%h", $time, obs_all, exp_all());
      end
      if (d_av === 1'b1) n_av++;
      if (d_hs === 1'b0) n_hs++;
      ea = exp_addr();
      if (ea >= 0) begin
        checks++;
        if (addr != ea) begin
          failures++;
          $display("FAIL line_addr0 t=%0t got=%0d want=%0d", $time, addr, ea);
        end
      end
      adv_addr();
    end
    checks++;
    if (n_av != TD.ha) begin
      failures++;
      $display("FAIL line_active_count got=%0d want=%0d", n_av, TD.ha);
    end
    checks++;
    if (n_hs != TD.hs) begin
      failures++;
      $display("FAIL line_hsync_count got=%0d want=%0d", n_hs, TD.hs);
    end
  endtask

  task automatic test_frame();
    int ea, n_inc, n_clr, n_vs, last_addr;
    for (int f = 0; f < 2; f++) begin
      n_inc = 0;
      n_clr = 0;
      n_vs = 0;
      last_addr = -1;
      for (int i = 0; i < NS; i++) begin
        @(negedge clk);
        checks++;
        if (obs_all !== exp_all()) begin
          failures++;
          $display("FAIL frame_vec t=%0t got=%h want=%h", $time, obs_all, exp_all());
        end
        if (s_ia === 1'b1) n_inc++;
        if (s_ra === 1'b1) n_clr++;
        if (s_vs === 1'b0) n_vs++;
        if (s_shown == (TS.va - 1) * HTS + TS.ha - 1) last_addr = addr;
        ea = exp_addr();
        if (ea >= 0) begin
          checks++;
          if (addr != ea) begin
            failures++;
            $display("FAIL frame_addr0 t=%0t got=%0d want=%0d", $time, addr, ea);
          end
        end
        adv_addr();
      end
      checks++;
      if (n_inc != TS.ha * TS.va) begin
        failures++;
        $display("FAIL frame_inc_count got=%0d want=%0d", n_inc, TS.ha * TS.va);
      end
      checks++;
      if (n_clr != 1) begin
        failures++;
        $display("FAIL frame_clr_count got=%0d want=1", n_clr);
      end
      checks++;
      if (n_vs != TS.vs * HTS) begin
        failures++;
        $display("FAIL frame_vsync_count got=%0d want=%0d", n_vs, TS.vs * HTS);
      end
      checks++;
`ifdef ADDR_PREFETCH_EN
      if (last_addr != TS.ha * TS.va) begin
        failures++;
        $display("FAIL frame_last_addr0 got=%0d want=%0d", last_addr, TS.ha * TS.va);
      end
`else
      if (last_addr != TS.ha * TS.va - 1) begin
        failures++;
        $display("FAIL frame_last_addr0 got=%0d want=%0d", last_addr, TS.ha * TS.va - 1);
      end
`endif
    end
  endtask

  task automatic test_midframe_reset();
    int ea, run, len;
    for (int k = 0; k < 4; k++) begin
      // First pass lands the reset on a fixed mid-frame pixel, the rest at random points.
      if (k == 0) run = (10 * HTS + 18 - s_shown + NS) % NS;
      else run = $urandom_range(NS, NS / 4);
      len = $urandom_range(3, 1);
      for (int i = 0; i < run + len + 3 * HTS; i++) begin
        Reset = (i >= run) && (i < run + len);
        @(negedge clk);
        checks++;
        if (obs_all !== exp_all()) begin
          failures++;
          $display("FAIL midreset_vec k=%0d t=%0t got=%h want=%h", k, $time, obs_all,
                   exp_all());
        end
        ea = exp_addr();
        if (ea >= 0) begin
          checks++;
          if (addr != ea) begin
            failures++;
            $display("FAIL midreset_addr0 k=%0d t=%0t got=%0d want=%0d", k, $time, addr, ea);
          end
        end
        adv_addr();
      end
      Reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_midframe_reset();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
